// File: rtl/lud_pkg.sv
// Shared constants and control-word layout helpers for the LU-decomposition datapath engine.
package lud_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam int unsigned SEL_MAC       = 0;
   localparam int unsigned SEL_DIV       = 1;
   localparam int unsigned SEL_BANK_BASE = 2;

   localparam int unsigned OP_MAC_A = 0;
   localparam int unsigned OP_MAC_B = 1;
   localparam int unsigned OP_MAC_C = 2;
   localparam int unsigned OP_DIV_A = 3;
   localparam int unsigned OP_DIV_B = 4;

   function automatic int unsigned sel_zero(input int unsigned nb);
      return 2 * nb + 2;
   endfunction

   function automatic int unsigned sel_width(input int unsigned nb);
      return $clog2(2 * nb + 3);
   endfunction

   function automatic int unsigned port_field_width(input int unsigned aw, input int unsigned nb);
      return aw + 1 + sel_width(nb);
   endfunction

   function automatic int unsigned ctrl_width(input int unsigned aw, input int unsigned nb);
      return 2 * nb * port_field_width(aw, nb) + 5 * sel_width(nb) + 1;
   endfunction

   // Port k = 2*bank + (0 for A, 1 for B); fields are packed MSB-first.
   function automatic int unsigned port_lsb(input int unsigned aw, input int unsigned nb,
                                            input int unsigned k);
      return ctrl_width(aw, nb) - (k + 1) * port_field_width(aw, nb);
   endfunction

   function automatic int unsigned op_lsb(input int unsigned aw, input int unsigned nb,
                                          input int unsigned j);
      return ctrl_width(aw, nb) - 2 * nb * port_field_width(aw, nb) - (j + 1) * sel_width(nb);
   endfunction

endpackage

// File: rtl/lud_bank_ram.sv
// True dual-port RAM bank: read-first, one-cycle registered read, port A wins on a shared write.
module lud_bank_ram #(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  en_a,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] din_a,
   output logic [DATA_WIDTH-1:0] dout_a,
   input  logic                  en_b,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] din_b,
   output logic [DATA_WIDTH-1:0] dout_b
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Port A is written last so it takes priority on an address clash.
   always_ff @(posedge clk) begin
      if (en_b) begin
         dout_b <= mem[addr_b];
         if (we_b) mem[addr_b] <= din_b;
      end
      if (en_a) begin
         dout_a <= mem[addr_a];
         if (we_a) mem[addr_a] <= din_a;
      end
   end

endmodule

// File: rtl/lud_datapath_engine.sv
// Control-word driven datapath: banked RAM, operand crossbar, MAC/divider issue and host access.
module lud_datapath_engine
   import lud_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 7,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_BANKS    = 2,
   parameter int unsigned DRAIN_CYCLES = 16,
   localparam int unsigned SEL_WIDTH   = sel_width(NUM_BANKS),
   localparam int unsigned CTRL_WIDTH  = ctrl_width(ADDR_WIDTH, NUM_BANKS),
   localparam int unsigned HB_WIDTH    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                  CLK_100,
   input  logic                  RST,
   input  logic                  start,
   input  logic [CTRL_WIDTH-1:0] ctrl_word,
   input  logic                  ctrl_valid,
   input  logic                  ctrl_last,
   output logic                  ctrl_ready,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           op_count,
   output logic                  err_collision,
   output logic                  host_err,
   input  logic                  host_en,
   input  logic                  host_we,
   input  logic [HB_WIDTH-1:0]   host_bank,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_din,
   output logic [DATA_WIDTH-1:0] host_dout,
   output logic                  host_dout_valid,
   output logic [DATA_WIDTH-1:0] mac_a,
   output logic [DATA_WIDTH-1:0] mac_b,
   output logic [DATA_WIDTH-1:0] mac_c,
   output logic                  mac_valid,
   input  logic [DATA_WIDTH-1:0] mac_result,
   output logic [DATA_WIDTH-1:0] div_a,
   output logic [DATA_WIDTH-1:0] div_b,
   output logic                  div_valid,
   input  logic [DATA_WIDTH-1:0] div_result
);

   localparam int unsigned NSRC = 1 << SEL_WIDTH;
   localparam int unsigned NP   = 2 * NUM_BANKS;

   logic [1:0]            state;
   logic [7:0]            drain_cnt;
   logic                  issue_valid;
   logic [CTRL_WIDTH-1:0] issue_word;
   logic [HB_WIDTH-1:0]   host_bank_q;

   logic accept;
   logic host_grant;

   logic [NP-1:0][ADDR_WIDTH-1:0] p_addr;
   logic [NP-1:0]                 p_we;
   logic [NP-1:0][SEL_WIDTH-1:0]  p_sel;
   logic [4:0][SEL_WIDTH-1:0]     op_sel;
   logic                          mac_neg;

   logic [NSRC-1:0][DATA_WIDTH-1:0]      src;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] dout_a;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] dout_b;
   logic [NUM_BANKS-1:0]                 coll;

   assign ctrl_ready = (state == ST_RUN);
   assign busy       = (state != ST_IDLE);
   assign accept     = ctrl_valid && (state == ST_RUN);
   assign host_grant = host_en && (state == ST_IDLE) && !start;
   assign host_dout  = host_dout_valid ? dout_a[host_bank_q] : '0;

   for (genvar k = 0; k < NP; k++) begin : g_port
      localparam int unsigned LSB = port_lsb(ADDR_WIDTH, NUM_BANKS, k);
      assign p_sel[k]  = issue_word[LSB +: SEL_WIDTH];
      assign p_we[k]   = issue_word[LSB + SEL_WIDTH];
      assign p_addr[k] = issue_word[LSB + SEL_WIDTH + 1 +: ADDR_WIDTH];
   end

   for (genvar j = 0; j < 5; j++) begin : g_op
      assign op_sel[j] = issue_word[op_lsb(ADDR_WIDTH, NUM_BANKS, j) +: SEL_WIDTH];
   end
   assign mac_neg = issue_word[0];

   // Crossbar sources; every code at or above the zero code reads as zero.
   assign src[SEL_MAC] = mac_result;
   assign src[SEL_DIV] = div_result;
   for (genvar z = sel_zero(NUM_BANKS); z < NSRC; z++) begin : g_zero
      assign src[z] = '0;
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic                  host_hit;
      logic                  en_a, we_a, we_b;
      logic [ADDR_WIDTH-1:0] addr_a;
      logic [DATA_WIDTH-1:0] din_a;

      assign src[SEL_BANK_BASE + 2*b]     = dout_a[b];
      assign src[SEL_BANK_BASE + 2*b + 1] = dout_b[b];

      assign host_hit = host_grant && (host_bank == HB_WIDTH'(b));
      assign coll[b]  = issue_valid && p_we[2*b] && p_we[2*b+1] && (p_addr[2*b] == p_addr[2*b+1]);
      assign en_a     = issue_valid || host_hit;
      assign we_a     = issue_valid ? p_we[2*b] : (host_hit && host_we);
      assign addr_a   = issue_valid ? p_addr[2*b] : host_addr;
      assign din_a    = issue_valid ? src[p_sel[2*b]] : host_din;
      assign we_b     = issue_valid && p_we[2*b+1] && !coll[b];

      lud_bank_ram #(
         .ADDR_WIDTH (ADDR_WIDTH),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
         .clk    (CLK_100),
         .en_a   (en_a),
         .we_a   (we_a),
         .addr_a (addr_a),
         .din_a  (din_a),
         .dout_a (dout_a[b]),
         .en_b   (issue_valid),
         .we_b   (we_b),
         .addr_b (p_addr[2*b+1]),
         .din_b  (src[p_sel[2*b+1]]),
         .dout_b (dout_b[b])
      );
   end

   always_ff @(posedge CLK_100 or posedge RST) begin
      if (RST) begin
         state           <= ST_IDLE;
         drain_cnt       <= '0;
         issue_valid     <= 1'b0;
         issue_word      <= '0;
         host_bank_q     <= '0;
         done            <= 1'b0;
         op_count        <= '0;
         err_collision   <= 1'b0;
         host_err        <= 1'b0;
         host_dout_valid <= 1'b0;
         mac_a           <= '0;
         mac_b           <= '0;
         mac_c           <= '0;
         mac_valid       <= 1'b0;
         div_a           <= '0;
         div_b           <= '0;
         div_valid       <= 1'b0;
      end else begin
         done            <= 1'b0;
         host_err        <= host_en && ((state != ST_IDLE) || start);
         host_dout_valid <= host_grant && !host_we;
         host_bank_q     <= host_bank;
         issue_valid     <= accept;
         if (accept) issue_word <= ctrl_word;

         mac_valid <= issue_valid;
         div_valid <= issue_valid;
         if (issue_valid) begin
            mac_a <= src[op_sel[OP_MAC_A]] ^ {mac_neg, {(DATA_WIDTH-1){1'b0}}};
            mac_b <= src[op_sel[OP_MAC_B]];
            mac_c <= src[op_sel[OP_MAC_C]];
            div_a <= src[op_sel[OP_DIV_A]];
            div_b <= src[op_sel[OP_DIV_B]];
            if (|coll) err_collision <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state         <= ST_RUN;
                  op_count      <= '0;
                  err_collision <= 1'b0;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
                  if (ctrl_last) begin
                     state     <= ST_DRAIN;
                     drain_cnt <= 8'(DRAIN_CYCLES);
                  end
               end
            end
            ST_DRAIN: begin
               drain_cnt <= drain_cnt - 8'd1;
               if (drain_cnt == 8'd1) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lud_datapath_engine.sv
// Directed bench for lud_datapath_engine with default parameters (60-bit control word).
module tb_lud_datapath_engine;

   logic        CLK_100 = 1'b0;
   logic        RST;
   logic        start;
   logic [59:0] ctrl_word;
   logic        ctrl_valid, ctrl_last, ctrl_ready;
   logic        busy, done, err_collision, host_err;
   logic [15:0] op_count;
   logic        host_en, host_we;
   logic [0:0]  host_bank;
   logic [6:0]  host_addr;
   logic [31:0] host_din, host_dout;
   logic        host_dout_valid;
   logic [31:0] mac_a, mac_b, mac_c, mac_result;
   logic        mac_valid;
   logic [31:0] div_a, div_b, div_result;
   logic        div_valid;

   int n_checks = 0;
   int n_fail   = 0;
   int cycles;
   int done_cnt;

   always #5 CLK_100 = ~CLK_100;

   lud_datapath_engine #(
      .ADDR_WIDTH   (7),
      .DATA_WIDTH   (32),
      .NUM_BANKS    (2),
      .DRAIN_CYCLES (16)
   ) dut (
      .CLK_100         (CLK_100),
      .RST             (RST),
      .start           (start),
      .ctrl_word       (ctrl_word),
      .ctrl_valid      (ctrl_valid),
      .ctrl_last       (ctrl_last),
      .ctrl_ready      (ctrl_ready),
      .busy            (busy),
      .done            (done),
      .op_count        (op_count),
      .err_collision   (err_collision),
      .host_err        (host_err),
      .host_en         (host_en),
      .host_we         (host_we),
      .host_bank       (host_bank),
      .host_addr       (host_addr),
      .host_din        (host_din),
      .host_dout       (host_dout),
      .host_dout_valid (host_dout_valid),
      .mac_a           (mac_a),
      .mac_b           (mac_b),
      .mac_c           (mac_c),
      .mac_valid       (mac_valid),
      .mac_result      (mac_result),
      .div_a           (div_a),
      .div_b           (div_b),
      .div_valid       (div_valid),
      .div_result      (div_result)
   );

   // Port field {addr[6:0], we, sel[2:0]}; word = {b0A, b0B, b1A, b1B, sa, sb, sc, da, db, neg}.
   function automatic logic [10:0] pf(input logic [6:0] addr, input logic we, input logic [2:0] sel);
      return {addr, we, sel};
   endfunction

   function automatic logic [59:0] mk_word(input logic [10:0] b0a, input logic [10:0] b0b,
                                           input logic [10:0] b1a, input logic [10:0] b1b,
                                           input logic [2:0] sa, input logic [2:0] sb,
                                           input logic [2:0] sc, input logic [2:0] da,
                                           input logic [2:0] db, input logic neg);
      return {b0a, b0b, b1a, b1b, sa, sb, sc, da, db, neg};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_100);
      #1;
   endtask

   initial begin
      logic [10:0] nop;
      nop = pf(7'd0, 1'b0, 3'd6);

      RST = 1'b1; start = 1'b0; ctrl_word = '0; ctrl_valid = 1'b0; ctrl_last = 1'b0;
      host_en = 1'b0; host_we = 1'b0; host_bank = '0; host_addr = '0; host_din = '0;
      mac_result = 32'h3F800000; div_result = 32'h40000000;
      #2;
      check("rst_busy", busy, 0);
      check("rst_ctrl_ready", ctrl_ready, 0);
      check("rst_done", done, 0);
      check("rst_op_count", op_count, 0);
      check("rst_err_collision", err_collision, 0);
      check("rst_host_err", host_err, 0);
      check("rst_host_dout_valid", host_dout_valid, 0);
      check("rst_host_dout", host_dout, 0);
      check("rst_mac_valid", mac_valid, 0);
      check("rst_div_valid", div_valid, 0);
      check("rst_mac_a", mac_a, 0);
      check("rst_div_a", div_a, 0);
      tick();
      RST = 1'b0;
      tick();

      // Host write 3.0 to bank0 addr 5, then read it back.
      host_en = 1'b1; host_we = 1'b1; host_bank = 1'b0; host_addr = 7'd5; host_din = 32'h40400000;
      tick();
      check("host_wr_no_valid", host_dout_valid, 0);
      host_we = 1'b0;
      tick();
      check("host_rd_valid", host_dout_valid, 1);
      check("host_rd_data", host_dout, 32'h40400000);
      host_en = 1'b0;
      tick();
      check("host_rd_valid_drop", host_dout_valid, 0);

      // Run 1: four words, last one closes the run.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("run_busy", busy, 1);
      check("run_ctrl_ready", ctrl_ready, 1);
      check("run_op_count_clear", op_count, 0);

      ctrl_valid = 1'b1;
      ctrl_word  = mk_word(pf(7'd5, 1'b0, 3'd6), nop, nop, nop, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 1'b0);
      tick();
      ctrl_word  = mk_word(nop, nop, nop, pf(7'd9, 1'b1, 3'd0), 3'd2, 3'd6, 3'd6, 3'd6, 3'd6, 1'b1);
      tick();
      ctrl_word  = mk_word(pf(7'd3, 1'b1, 3'd0), pf(7'd3, 1'b1, 3'd1), nop, nop,
                           3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 1'b0);
      tick();
      check("neg_mac_a", mac_a, 32'hC0400000);
      check("neg_mac_valid", mac_valid, 1);
      check("neg_mac_b_zero", mac_b, 0);
      check("no_collision_yet", err_collision, 0);
      ctrl_word  = mk_word(nop, nop, nop, nop, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 1'b0);
      ctrl_last  = 1'b1;
      tick();
      ctrl_valid = 1'b0; ctrl_last = 1'b0;
      check("last_op_count", op_count, 4);
      check("drain_ctrl_ready", ctrl_ready, 0);
      check("drain_busy", busy, 1);
      check("collision_flag", err_collision, 1);

      host_en = 1'b1; host_we = 1'b0; host_bank = 1'b1; host_addr = 7'd9;
      tick();
      check("drain_host_err", host_err, 1);
      check("drain_host_refused", host_dout_valid, 0);
      host_en = 1'b0;
      tick();
      check("drain_host_err_pulse", host_err, 0);
      check("mac_valid_one_cycle", mac_valid, 0);
      cycles = 2;
      while (!done && cycles < 40) begin
         tick();
         cycles++;
      end
      check("drain_length", cycles, 16);
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_op_count", op_count, 4);

      // Readback of MAC-result write and collision outcome.
      host_en = 1'b1; host_we = 1'b0; host_bank = 1'b1; host_addr = 7'd9;
      tick();
      check("done_low", done, 0);
      check("bank1_addr9", host_dout, 32'h3F800000);
      host_bank = 1'b0; host_addr = 7'd3;
      tick();
      check("bank0_addr3", host_dout, 32'h3F800000);
      host_addr = 7'd5;
      tick();
      check("bank0_addr5", host_dout, 32'h40400000);
      host_en = 1'b0;
      tick();

      // Run 2: crossbar sources incl. out-of-range code, then abort by reset.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("run2_err_cleared", err_collision, 0);
      ctrl_valid = 1'b1;
      ctrl_word  = mk_word(nop, nop, nop, nop, 3'd0, 3'd1, 3'd6, 3'd1, 3'd7, 1'b0);
      tick();
      ctrl_valid = 1'b0;
      tick();
      check("xbar_mac_a", mac_a, 32'h3F800000);
      check("xbar_mac_b", mac_b, 32'h40000000);
      check("xbar_div_a", div_a, 32'h40000000);
      check("xbar_div_b_code7", div_b, 0);
      check("xbar_div_valid", div_valid, 1);
      RST = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_mac_a", mac_a, 0);
      check("abort_div_a", div_a, 0);
      check("abort_op_count", op_count, 0);
      check("abort_ctrl_ready", ctrl_ready, 0);
      tick();
      RST = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) done_cnt++;
      end
      check("abort_no_done", done_cnt, 0);

      // Run 3: start with a coincident host request, single last word.
      start = 1'b1; host_en = 1'b1; host_we = 1'b0; host_bank = 1'b0; host_addr = 7'd5;
      tick();
      start = 1'b0; host_en = 1'b0;
      check("run3_busy", busy, 1);
      check("start_host_err", host_err, 1);
      check("start_host_refused", host_dout_valid, 0);
      ctrl_valid = 1'b1; ctrl_last = 1'b1;
      ctrl_word  = mk_word(nop, nop, nop, nop, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 1'b0);
      tick();
      ctrl_valid = 1'b0; ctrl_last = 1'b0;
      check("run3_op_count", op_count, 1);
      cycles = 0;
      while (!done && cycles < 40) begin
         tick();
         cycles++;
      end
      check("run3_drain_length", cycles, 16);
      check("run3_done_op_count", op_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
